// File: rtl/wb_spi_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SPI-register bridge.
package wb_spi_bridge_pkg;

  localparam int unsigned ADR_W        = 8;
  localparam int unsigned DAT_W        = 8;
  localparam int unsigned SADR_W       = 3;
  localparam int unsigned SPI_WIN_SIZE = 8;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned ADR_EXT_W    = ADR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_ERR,
    ST_DONE
  } state_t;

  // Extra MSB keeps base+size from wrapping when the window sits at the top of the map.
  function automatic logic in_window(input logic [ADR_W-1:0] adr,
                                     input logic [ADR_W-1:0] base);
    logic [ADR_EXT_W-1:0] a;
    logic [ADR_EXT_W-1:0] lo;
    logic [ADR_EXT_W-1:0] hi;
    a  = {1'b0, adr};
    lo = {1'b0, base};
    hi = lo + ADR_EXT_W'(SPI_WIN_SIZE);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/wb_spi_bridge_if.sv
// Bus bundle between the upstream Wishbone master, the bridge and the SPI core.
interface wb_spi_bridge_if
  import wb_spi_bridge_pkg::*;
;

  logic              m_cyc_i;
  logic              m_stb_i;
  logic              m_we_i;
  logic [ADR_W-1:0]  m_adr_i;
  logic [DAT_W-1:0]  m_dat_i;
  logic [DAT_W-1:0]  m_dat_o;
  logic              m_ack_o;
  logic              m_err_o;
  logic              m_rty_o;

  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [SADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0]  s_dat_o;
  logic [DAT_W-1:0]  s_dat_i;
  logic              s_ack_i;

  // Bridge side: slave to the upstream master, master to the SPI core.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );

  // Environment side: upstream master plus SPI core.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Slave-ack wait counter; only built when WB_SPI_BRIDGE_TIMEOUT_EN is defined.
module wb_timeout_cnt
  import wb_spi_bridge_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired_c
);

  localparam int unsigned EXT_W = CNT_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [EXT_W-1:0] w_next;

  assign w_next = {1'b0, r_cnt} + EXT_W'(1);

  // Expiry is flagged in the cycle whose increment would reach the limit.
  assign o_expired_c = i_enable && (w_next == {1'b0, i_limit});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/wb_spi_bridge.sv
// Wishbone-to-SPI register window bridge; one slave cycle per master strobe.
// Optional slave-ack timeout compiled in with WB_SPI_BRIDGE_TIMEOUT_EN.
module wb_spi_bridge
  import wb_spi_bridge_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  parameter logic [ADR_W-1:0] SPI_BASE       = 8'h00
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_spi_bridge_if.slave io_bus
);

  state_t            r_state;
  logic [DAT_W-1:0]  r_m_dat;
  logic              r_m_ack;
  logic              r_m_err;
  logic              r_s_cyc;
  logic              r_s_stb;
  logic              r_s_we;
  logic [SADR_W-1:0] r_s_adr;
  logic [DAT_W-1:0]  r_s_dat;

  logic              w_req;
  logic              w_hit;
  logic [SADR_W-1:0] w_offset;
  logic              w_expired;

  assign w_req    = io_bus.m_cyc_i & io_bus.m_stb_i;
  assign w_hit    = in_window(io_bus.m_adr_i, SPI_BASE);
  assign w_offset = SADR_W'(io_bus.m_adr_i - SPI_BASE);

`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  wb_timeout_cnt u_timeout (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_clear     (r_state != ST_XFER),
    .i_enable    ((r_state == ST_XFER) && io_bus.m_cyc_i && !io_bus.s_ack_i),
    .i_limit     (CNT_W'(TIMEOUT_CYCLES)),
    .o_expired_c (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Control FSM; s_we/s_adr/s_dat double as the request latch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_m_dat <= '0;
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      r_s_cyc <= 1'b0;
      r_s_stb <= 1'b0;
      r_s_we  <= 1'b0;
      r_s_adr <= '0;
      r_s_dat <= '0;
    end else begin
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              r_s_we  <= io_bus.m_we_i;
              r_s_adr <= w_offset;
              r_s_dat <= io_bus.m_dat_i;
              r_s_cyc <= 1'b1;
              r_s_stb <= 1'b1;
              r_state <= ST_XFER;
            end else begin
              r_m_err <= 1'b1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_XFER: begin
          // Abort beats a simultaneous ack so a dropped cycle never sees an ack.
          if (!io_bus.m_cyc_i) begin
            r_s_cyc <= 1'b0;
            r_s_stb <= 1'b0;
            r_state <= ST_IDLE;
          end else if (io_bus.s_ack_i) begin
            if (!r_s_we) begin
              r_m_dat <= io_bus.s_dat_i;
            end
            r_m_ack <= 1'b1;
            r_s_cyc <= 1'b0;
            r_s_stb <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_m_err <= 1'b1;
            r_s_cyc <= 1'b0;
            r_s_stb <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_ERR: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!io_bus.m_stb_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.m_dat_o = r_m_dat;
  assign io_bus.m_ack_o = r_m_ack;
  assign io_bus.m_err_o = r_m_err;
  assign io_bus.m_rty_o = 1'b0;
  assign io_bus.s_cyc_o = r_s_cyc;
  assign io_bus.s_stb_o = r_s_stb;
  assign io_bus.s_we_o  = r_s_we;
  assign io_bus.s_adr_o = r_s_adr;
  assign io_bus.s_dat_o = r_s_dat;

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Randomized transaction-level bench for wb_spi_bridge.
module tb_wb_spi_bridge;
  import wb_spi_bridge_pkg::*;

  localparam int unsigned TO   = 4;
  localparam logic [7:0]  BASE = 8'h00;
`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_spi_bridge_if u_bus ();

  wb_spi_bridge #(.TIMEOUT_CYCLES(TO), .SPI_BASE(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_bus   (u_bus)
  );

  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         n_both = 0;
  logic [7:0] model_mdat = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] out_vec();
    return {u_bus.m_dat_o, u_bus.m_ack_o, u_bus.m_err_o, u_bus.m_rty_o,
            u_bus.s_cyc_o, u_bus.s_stb_o, u_bus.s_we_o, u_bus.s_adr_o, u_bus.s_dat_o};
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (u_bus.m_ack_o === 1'b1 && u_bus.m_err_o === 1'b1) n_both++;
  end

  task automatic idle_inputs();
    u_bus.m_cyc_i = 1'b0;
    u_bus.m_stb_i = 1'b0;
    u_bus.m_we_i  = 1'b0;
    u_bus.m_adr_i = 8'h00;
    u_bus.m_dat_i = 8'h00;
    u_bus.s_ack_i = 1'b0;
    u_bus.s_dat_i = 8'h00;
  endtask

  // One master strobe; slave acks in its (d+1)-th strobed cycle; strobe held 'hold' cycles past the response.
  task automatic do_xfer(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                         input int d, input logic [7:0] rd, input int hold);
    bit in_win, exp_to, exp_ack, evt, got_first;
    int exp_stb, exp_evt, limit;
    int stb_n, ack_n, err_n, evt_at, bad_fld, cyc, post, first_stb;
    logic [7:0] exp_mdat, got_dat;
    logic [2:0] got_adr;
    logic       got_we;
    stb_n = 0; ack_n = 0; err_n = 0; evt_at = 0; bad_fld = 0; cyc = 0; post = 0;
    first_stb = 0; evt = 0; got_first = 0; got_adr = '0; got_we = 1'b0; got_dat = '0;

    in_win   = (int'(adr) >= int'(BASE)) && (int'(adr) - int'(BASE) < 8);
    exp_to   = TO_EN && in_win && (d + 1 > int'(TO));
    exp_ack  = in_win && !exp_to;
    exp_stb  = !in_win ? 0 : (exp_to ? int'(TO) : d + 1);
    exp_evt  = !in_win ? 1 : exp_stb + 1;
    exp_mdat = (exp_ack && !we) ? rd : model_mdat;
    limit    = d + int'(TO) + hold + 20;

    @(negedge clk);
    u_bus.m_cyc_i = 1'b1;
    u_bus.m_stb_i = 1'b1;
    u_bus.m_we_i  = we;
    u_bus.m_adr_i = adr;
    u_bus.m_dat_i = wdat;
    while (cyc < limit && !(evt && post >= hold)) begin
      @(negedge clk);
      cyc++;
      if (evt) post++;
      if (u_bus.s_stb_o === 1'b1) begin
        stb_n++;
        if (!got_first) begin
          got_first = 1'b1; first_stb = cyc;
          got_adr = u_bus.s_adr_o; got_we = u_bus.s_we_o; got_dat = u_bus.s_dat_o;
        end else if ({u_bus.s_adr_o, u_bus.s_we_o, u_bus.s_dat_o} !== {got_adr, got_we, got_dat}) begin
          bad_fld++;
        end
      end
      if (u_bus.s_cyc_o !== u_bus.s_stb_o) bad_fld++;
      if (u_bus.m_ack_o === 1'b1) begin
        ack_n++;
        if (!evt) begin
          evt = 1'b1; evt_at = cyc;
          check("ack_mdat", 32'(u_bus.m_dat_o), 32'(exp_mdat));
        end
      end
      if (u_bus.m_err_o === 1'b1) begin
        err_n++;
        if (!evt) begin evt = 1'b1; evt_at = cyc; end
      end
      u_bus.s_ack_i = (u_bus.s_stb_o === 1'b1) && (stb_n == d + 1);
      u_bus.s_dat_i = u_bus.s_ack_i ? rd : 8'($urandom);
    end
    u_bus.m_cyc_i = 1'b0;
    u_bus.m_stb_i = 1'b0;
    u_bus.s_ack_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (u_bus.s_stb_o === 1'b1) stb_n++;
      if (u_bus.m_ack_o === 1'b1) ack_n++;
      if (u_bus.m_err_o === 1'b1) err_n++;
    end

    check("evt_seen", 32'(evt), 32'd1);
    check("evt_cycle", 32'(evt_at), 32'(exp_evt));
    check("ack_cnt", 32'(ack_n), 32'(exp_ack));
    check("err_cnt", 32'(err_n), 32'(!exp_ack));
    check("stb_cycles", 32'(stb_n), 32'(exp_stb));
    if (in_win) begin
      check("stb_first", 32'(first_stb), 32'd1);
      check("s_adr", 32'(got_adr), 32'(3'(adr - BASE)));
      check("s_we", 32'(got_we), 32'(we));
      check("s_dat", 32'(got_dat), 32'(wdat));
    end
    check("fld_stable", 32'(bad_fld), 32'd0);
    check("mdat_hold", 32'(u_bus.m_dat_o), 32'(exp_mdat));
    model_mdat = exp_mdat;
  endtask

  // Master drops m_cyc_i after k strobed cycles with no slave response.
  task automatic do_abort(input logic [7:0] adr, input int k);
    int ack_n, err_n, stb_n;
    ack_n = 0; err_n = 0; stb_n = 0;
    @(negedge clk);
    u_bus.m_cyc_i = 1'b1; u_bus.m_stb_i = 1'b1; u_bus.m_we_i = 1'b0;
    u_bus.m_adr_i = adr;  u_bus.m_dat_i = 8'h00; u_bus.s_ack_i = 1'b0;
    repeat (k) begin
      @(negedge clk);
      ack_n += int'(u_bus.m_ack_o); err_n += int'(u_bus.m_err_o);
    end
    check("abort_pre", 32'(u_bus.s_stb_o), 32'd1);
    u_bus.m_cyc_i = 1'b0;
    @(negedge clk);
    check("abort_drop", 32'({u_bus.s_cyc_o, u_bus.s_stb_o}), 32'd0);
    ack_n += int'(u_bus.m_ack_o); err_n += int'(u_bus.m_err_o);
    u_bus.m_stb_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ack_n += int'(u_bus.m_ack_o); err_n += int'(u_bus.m_err_o);
      stb_n += int'(u_bus.s_stb_o);
    end
    check("abort_ack", 32'(ack_n), 32'd0);
    check("abort_err", 32'(err_n), 32'd0);
    check("abort_stb", 32'(stb_n), 32'd0);
    check("abort_mdat", 32'(u_bus.m_dat_o), 32'(model_mdat));
  endtask

  // Asynchronous reset while the slave strobe is up.
  task automatic do_reset_mid();
    @(negedge clk);
    u_bus.m_cyc_i = 1'b1; u_bus.m_stb_i = 1'b1; u_bus.m_we_i = 1'b1;
    u_bus.m_adr_i = 8'h01; u_bus.m_dat_i = 8'h5A; u_bus.s_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre", 32'(u_bus.s_stb_o), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'(out_vec()), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_mdat = 8'h00;
    @(negedge clk);
    check("rst_hold", 32'(out_vec()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(out_vec()), 32'd0);
    rst = 1'b0;

    do_xfer(1'b1, 8'h03, 8'hA5, 2, 8'h00, 0);
    do_xfer(1'b0, 8'h02, 8'h00, 0, 8'h5C, 2);
    do_xfer(1'b0, 8'h40, 8'h11, 0, 8'h99, 0);
    do_xfer(1'b1, 8'h07, 8'h3C, 1, 8'hEE, 10);
    do_xfer(1'b0, 8'h08, 8'h00, 0, 8'h42, 0);
    do_xfer(1'b0, 8'h00, 8'h00, 1, 8'h81, 0);
    do_xfer(1'b0, 8'h05, 8'h00, int'(TO) - 1, 8'hC3, 0);
    do_xfer(1'b0, 8'h06, 8'h00, int'(TO) + 6, 8'h77, 3);
    do_xfer(1'b1, 8'h04, 8'hFF, int'(TO), 8'h00, 0);
    do_abort(8'h04, 2);
    do_xfer(1'b0, 8'h01, 8'h00, 0, 8'h36, 0);
    do_reset_mid();
    do_xfer(1'b1, 8'h03, 8'hC7, 1, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] adr;
      adr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(BASE + 8'($urandom_range(0, 7)));
      do_xfer(1'($urandom), adr, 8'($urandom), int'($urandom_range(0, 6)),
              8'($urandom), int'($urandom_range(0, 3)));
    end

    check("rty_const", 32'(u_bus.m_rty_o), 32'd0);
    check("ack_err_excl", 32'(n_both), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
